// File: rtl/fdiv_if.sv
// Operand/result bundle between the FPU issue logic and the iterative divider.
// The master drives operands and start; the slave returns the handshake and result.
interface fdiv_if;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        start;
    logic        ready;
    logic [31:0] y;
    logic        done;
    logic        ovf;

    modport master (output x1, x2, start, input ready, y, done, ovf);
    modport slave  (input x1, x2, start, output ready, y, done, ovf);
endinterface

// File: rtl/fdiv.sv
// Iterative binary32 divider: radix-2 restoring mantissa division, constant latency,
// no NaN, subnormals read as zero, quotient truncated toward zero.
module fdiv (
    input logic  clk,
    input logic  rst,
    fdiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t             state_q, state_d;
    logic [4:0]         count_q, count_d;
    logic [24:0]        rem_q, rem_d;
    logic [24:0]        quo_q, quo_d;
    logic [23:0]        mb_q, mb_d;
    logic [9:0]         expDiff_q, expDiff_d;
    logic               sign_q, sign_d;
    logic               special_q, special_d;
    logic [31:0]        specialY_q, specialY_d;
    logic [31:0]        y_q, y_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               sign;
    logic               x1Zero, x2Zero, x1Inf, x2Inf;
    logic [23:0]        diff;
    logic signed [9:0]  expAdj;
    logic [22:0]        mant;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        mb_d       = mb_q;
        expDiff_d  = expDiff_q;
        sign_d     = sign_q;
        special_d  = special_q;
        specialY_d = specialY_q;
        y_d        = y_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        sign   = bus.x1[31] ^ bus.x2[31];
        x1Zero = (bus.x1[30:23] == 8'h00);
        x2Zero = (bus.x2[30:23] == 8'h00);
        x1Inf  = (bus.x1[30:23] == 8'hFF);
        x2Inf  = (bus.x2[30:23] == 8'hFF);
        diff   = rem_q[23:0] - mb_q;
        expAdj = $signed(expDiff_q) + (quo_q[24] ? 10'sd127 : 10'sd126);
        mant   = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = DIV;
                    // Counter holds iterations still to run; the zero cycle is the hop to NORM.
                    count_d   = 5'd25;
                    rem_d     = {2'b01, bus.x1[22:0]};
                    quo_d     = '0;
                    mb_d      = {1'b1, bus.x2[22:0]};
                    sign_d    = sign;
                    expDiff_d = {2'b00, bus.x1[30:23]} - {2'b00, bus.x2[30:23]};
                    special_d = x1Zero | x2Zero | x1Inf | x2Inf;
                    if (x1Zero)
                        specialY_d = {sign, 31'b0};
                    else if (x2Zero || x1Inf)
                        specialY_d = {sign, 8'hFF, 23'b0};
                    else
                        specialY_d = {sign, 31'b0};
                end
            end
            DIV: begin
                if (count_q == 5'd0) begin
                    state_d = NORM;
                end else begin
                    count_d = count_q - 5'd1;
                    if (rem_q >= {1'b0, mb_q}) begin
                        quo_d = {quo_q[23:0], 1'b1};
                        rem_d = {diff, 1'b0};
                    end else begin
                        quo_d = {quo_q[23:0], 1'b0};
                        rem_d = {rem_q[23:0], 1'b0};
                    end
                end
            end
            NORM: begin
                state_d = IDLE;
                done_d  = 1'b1;
                ovf_d   = 1'b0;
                if (special_q) begin
                    y_d = specialY_q;
                end else if (expAdj >= 10'sd255) begin
                    y_d   = {sign_q, 8'hFF, 23'b0};
                    ovf_d = 1'b1;
                end else if (expAdj <= 10'sd0) begin
                    y_d = {sign_q, 31'b0};
                end else begin
                    y_d = {sign_q, expAdj[7:0], mant};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            mb_q       <= '0;
            expDiff_q  <= '0;
            sign_q     <= 1'b0;
            special_q  <= 1'b0;
            specialY_q <= '0;
            y_q        <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            mb_q       <= mb_d;
            expDiff_q  <= expDiff_d;
            sign_q     <= sign_d;
            special_q  <= special_d;
            specialY_q <= specialY_d;
            y_q        <= y_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.y     = y_q;
    assign bus.ovf   = ovf_q;
    assign bus.done  = done_q;

endmodule
